yarp_mem_arbiter: RTL and testbench

Single-port memory arbiter for the YARP core: shares one backing memory port between the instruction-fetch requester and the load/store requester. Data requests come from the control/execute path (data_req/data_wr/data_byte); fetch requests come from the fetch stage. Serialises both onto one outstanding memory transaction and generates the pipeline stall that feeds the control unit's `control_d_cache_busy_in`.

---
 rtl/yarp_pkg.sv | 28 ++
 rtl/yarp_arb_pick.sv | 42 ++++
 rtl/yarp_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_yarp_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// +----------------------------------------------------------------------------+
// | yarp_pkg : shared YARP types (access sizes, memory arbiter state/winner).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_IFETCH = 2'b01,
    ARB_DATA   = 2'b10
  } arb_state_t;

  typedef enum logic {
    WIN_IMEM = 1'b0,
    WIN_DMEM = 1'b1
  } arb_winner_t;

endpackage

`default_nettype wire

// File: rtl/yarp_arb_pick.sv
// +----------------------------------------------------------------------------+
// | yarp_arb_pick : combinational fetch/data winner select.                    |
// | YARP_ARB_FAIR_EN selects alternating priority on contention, else data.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module yarp_arb_pick
  import yarp_pkg::*;
(
  input  logic        imem_req,
  input  logic        dmem_req,
  input  arb_winner_t last_winner,
  output arb_winner_t winner
);

`ifdef YARP_ARB_FAIR_EN
  // On contention the requester that was not served last goes first.
  always_comb begin
    winner = WIN_IMEM;
    if (imem_req && dmem_req) begin
      winner = (last_winner == WIN_DMEM) ? WIN_IMEM : WIN_DMEM;
    end else if (dmem_req) begin
      winner = WIN_DMEM;
    end
  end
`else
  logic unused_pick_inputs;

  assign unused_pick_inputs = imem_req ^ last_winner;

  always_comb begin
    winner = WIN_IMEM;
    if (dmem_req) begin
      winner = WIN_DMEM;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/yarp_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | yarp_mem_arbiter : shares one memory port between fetch and load/store.    |
// | Optional YARP_ARB_FAIR_EN enables last-winner fair arbitration.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              imem_req_i,
  input  logic [ADDR_W-1:0] imem_addr_i,
  output logic              imem_gnt_o,
  output logic              imem_rvalid_o,
  output logic [DATA_W-1:0] imem_rdata_o,

  input  logic              dmem_req_i,
  input  logic              dmem_wr_i,
  input  logic [1:0]        dmem_byte_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [DATA_W-1:0] dmem_wdata_i,
  output logic              dmem_gnt_o,
  output logic              dmem_rvalid_o,
  output logic [DATA_W-1:0] dmem_rdata_o,

  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_byte_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              stall_o
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  arb_winner_t winner;
  arb_winner_t last_winner;

  logic start_fetch;
  logic start_data;
  logic done_fetch;
  logic done_data;

  yarp_arb_pick u_pick (
    .imem_req    (imem_req_i),
    .dmem_req    (dmem_req_i),
    .last_winner (last_winner),
    .winner      (winner)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (dmem_req_i || imem_req_i) begin
          state_nxt = (winner == WIN_DMEM) ? ARB_DATA : ARB_IFETCH;
        end
      end
      ARB_IFETCH, ARB_DATA: begin
        if (mem_ready_i) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign start_fetch = (state == ARB_IDLE) && (state_nxt == ARB_IFETCH);
  assign start_data  = (state == ARB_IDLE) && (state_nxt == ARB_DATA);
  assign done_fetch  = (state == ARB_IFETCH) && mem_ready_i;
  assign done_data   = (state == ARB_DATA) && mem_ready_i;

  assign mem_req_o = (state != ARB_IDLE);
  assign stall_o   = dmem_req_i | (state == ARB_DATA);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ARB_IDLE;
      imem_gnt_o    <= 1'b0;
      dmem_gnt_o    <= 1'b0;
      imem_rvalid_o <= 1'b0;
      dmem_rvalid_o <= 1'b0;
      imem_rdata_o  <= '0;
      dmem_rdata_o  <= '0;
      mem_wr_o      <= 1'b0;
      mem_byte_o    <= 2'b00;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
    end else begin
      state         <= state_nxt;
      imem_gnt_o    <= start_fetch;
      dmem_gnt_o    <= start_data;
      imem_rvalid_o <= done_fetch;
      dmem_rvalid_o <= done_data;
      if (start_data) begin
        mem_wr_o    <= dmem_wr_i;
        mem_byte_o  <= dmem_byte_i;
        mem_addr_o  <= dmem_addr_i;
        mem_wdata_o <= dmem_wdata_i;
      end else if (start_fetch) begin
        mem_wr_o    <= 1'b0;
        mem_byte_o  <= WORD;
        mem_addr_o  <= imem_addr_i;
        mem_wdata_o <= '0;
      end
      if (done_fetch) begin
        imem_rdata_o <= mem_rdata_i;
      end
      // Stores complete without touching the load data register.
      if (done_data && !mem_wr_o) begin
        dmem_rdata_o <= mem_rdata_i;
      end
    end
  end

`ifdef YARP_ARB_FAIR_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_winner <= WIN_IMEM;
    end else if (start_fetch) begin
      last_winner <= WIN_IMEM;
    end else if (start_data) begin
      last_winner <= WIN_DMEM;
    end
  end
`else
  assign last_winner = WIN_IMEM;
`endif

endmodule

`default_nettype wire

// File: tb/tb_yarp_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_yarp_mem_arbiter : directed self-checking bench for yarp_mem_arbiter.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_yarp_mem_arbiter;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_gnt_o;
  logic        imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i;
  logic        dmem_wr_i;
  logic [1:0]  dmem_byte_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_wdata_i;
  logic        dmem_gnt_o;
  logic        dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [1:0]  mem_byte_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;

  int checks   = 0;
  int failures = 0;

  yarp_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_i    (imem_req_i),
    .imem_addr_i   (imem_addr_i),
    .imem_gnt_o    (imem_gnt_o),
    .imem_rvalid_o (imem_rvalid_o),
    .imem_rdata_o  (imem_rdata_o),
    .dmem_req_i    (dmem_req_i),
    .dmem_wr_i     (dmem_wr_i),
    .dmem_byte_i   (dmem_byte_i),
    .dmem_addr_i   (dmem_addr_i),
    .dmem_wdata_i  (dmem_wdata_i),
    .dmem_gnt_o    (dmem_gnt_o),
    .dmem_rvalid_o (dmem_rvalid_o),
    .dmem_rdata_o  (dmem_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_wr_o      (mem_wr_o),
    .mem_byte_o    (mem_byte_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rdata_i   (mem_rdata_i),
    .stall_o       (stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    checks++;
    if ({imem_gnt_o, imem_rvalid_o, imem_rdata_o, dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
         mem_req_o, mem_wr_o, mem_byte_o, mem_addr_o, mem_wdata_o, stall_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b%b rv=%b%b req=%b stall=%b addr=%h want all 0",
               imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o, mem_req_o, stall_o, mem_addr_o);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({mem_req_o, imem_gnt_o, dmem_gnt_o, stall_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release_idle got req/ignt/dgnt/stall=%b want 0000",
               {mem_req_o, imem_gnt_o, dmem_gnt_o, stall_o});
    end
  endtask

  task automatic test_single_load;
    dmem_req_i = 1'b1; dmem_wr_i = 1'b0; dmem_byte_i = SZ_WORD;
    dmem_addr_i = 32'h100; dmem_wdata_i = 32'h0;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin failures++; $display("FAIL load_stall_on_req got=%b want=1", stall_o); end
    tick();
    checks++;
    if ({dmem_gnt_o, imem_gnt_o, mem_req_o} !== 3'b101) begin
      failures++; $display("FAIL load_grant got dgnt/ignt/req=%b want 101", {dmem_gnt_o, imem_gnt_o, mem_req_o});
    end
    checks++;
    if ({mem_wr_o, mem_byte_o, mem_addr_o} !== {1'b0, SZ_WORD, 32'h100}) begin
      failures++; $display("FAIL load_attrs got wr=%b byte=%b addr=%h want 0/11/00000100", mem_wr_o, mem_byte_o, mem_addr_o);
    end
    dmem_req_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({dmem_gnt_o, mem_req_o, stall_o} !== 3'b011) begin
        failures++; $display("FAIL load_busy cycle %0d got gnt/req/stall=%b want 011", i, {dmem_gnt_o, mem_req_o, stall_o});
      end
    end
    tick();
    mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    checks++;
    if ({dmem_rvalid_o, imem_rvalid_o, mem_req_o, stall_o} !== 4'b1000) begin
      failures++; $display("FAIL load_complete got drv/irv/req/stall=%b want 1000",
                           {dmem_rvalid_o, imem_rvalid_o, mem_req_o, stall_o});
    end
    checks++;
    if (dmem_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h want=deadbeef", dmem_rdata_o); end
    mem_ready_i = 1'b0;
    tick();
    checks++;
    if ({dmem_rvalid_o, dmem_rdata_o} !== {1'b0, 32'hDEADBEEF}) begin
      failures++; $display("FAIL load_rvalid_pulse got rv=%b rdata=%h want 0/deadbeef", dmem_rvalid_o, dmem_rdata_o);
    end
  endtask

  task automatic test_zero_wait_fetch;
    mem_ready_i = 1'b1; mem_rdata_i = 32'h00000013;
    imem_req_i = 1'b1; imem_addr_i = 32'h0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL fetch_stall_req got=%b want=0", stall_o); end
    tick();
    checks++;
    if ({imem_gnt_o, dmem_gnt_o, mem_req_o, stall_o} !== 4'b1010) begin
      failures++; $display("FAIL fetch_grant got ignt/dgnt/req/stall=%b want 1010", {imem_gnt_o, dmem_gnt_o, mem_req_o, stall_o});
    end
    checks++;
    if ({mem_wr_o, mem_byte_o, mem_addr_o} !== {1'b0, SZ_WORD, 32'h0}) begin
      failures++; $display("FAIL fetch_attrs got wr=%b byte=%b addr=%h want 0/11/00000000", mem_wr_o, mem_byte_o, mem_addr_o);
    end
    imem_req_i = 1'b0;
    tick();
    checks++;
    if ({imem_rvalid_o, dmem_rvalid_o, mem_req_o, stall_o} !== 4'b1000) begin
      failures++; $display("FAIL fetch_complete got irv/drv/req/stall=%b want 1000",
                           {imem_rvalid_o, dmem_rvalid_o, mem_req_o, stall_o});
    end
    checks++;
    if (imem_rdata_o !== 32'h00000013) begin failures++; $display("FAIL fetch_rdata got=%h want=00000013", imem_rdata_o); end
    mem_ready_i = 1'b0;
    tick();
    checks++;
    if ({imem_rvalid_o, mem_req_o, stall_o} !== 3'b000) begin
      failures++; $display("FAIL fetch_after got irv/req/stall=%b want 000", {imem_rvalid_o, mem_req_o, stall_o});
    end
  endtask

  task automatic test_simultaneous;
    imem_req_i = 1'b1; imem_addr_i = 32'h40;
    dmem_req_i = 1'b1; dmem_wr_i = 1'b1; dmem_byte_i = SZ_BYTE;
    dmem_addr_i = 32'h204; dmem_wdata_i = 32'h55;
    tick();
    checks++;
    if ({dmem_gnt_o, imem_gnt_o} !== 2'b10) begin
      failures++; $display("FAIL sim_data_first got dgnt/ignt=%b want 10", {dmem_gnt_o, imem_gnt_o});
    end
    checks++;
    if ({mem_wr_o, mem_byte_o, mem_addr_o, mem_wdata_o} !== {1'b1, SZ_BYTE, 32'h204, 32'h55}) begin
      failures++; $display("FAIL sim_store_attrs got wr=%b byte=%b addr=%h wdata=%h want 1/00/00000204/00000055",
                           mem_wr_o, mem_byte_o, mem_addr_o, mem_wdata_o);
    end
    dmem_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    tick();
    checks++;
    if ({dmem_rvalid_o, mem_req_o, imem_gnt_o} !== 3'b100) begin
      failures++; $display("FAIL sim_store_done got drv/req/ignt=%b want 100", {dmem_rvalid_o, mem_req_o, imem_gnt_o});
    end
    checks++;
    if (dmem_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL sim_store_keeps_rdata got=%h want=deadbeef", dmem_rdata_o); end
    // Second contention: a fresh load arrives while the fetch is still waiting.
    dmem_req_i = 1'b1; dmem_wr_i = 1'b0; dmem_byte_i = SZ_WORD;
    dmem_addr_i = 32'h300; dmem_wdata_i = 32'h0; mem_ready_i = 1'b0;
    tick();
`ifdef YARP_ARB_FAIR_EN
    checks++;
    if ({imem_gnt_o, dmem_gnt_o, mem_addr_o} !== {2'b10, 32'h40}) begin
      failures++; $display("FAIL sim2_fetch_first got ignt/dgnt=%b addr=%h want 10/00000040", {imem_gnt_o, dmem_gnt_o}, mem_addr_o);
    end
    imem_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick();
    checks++;
    if ({imem_rvalid_o, imem_rdata_o} !== {1'b1, 32'h12345678}) begin
      failures++; $display("FAIL sim2_fetch_done got rv=%b rdata=%h want 1/12345678", imem_rvalid_o, imem_rdata_o);
    end
    mem_ready_i = 1'b0;
    tick();
    checks++;
    if ({dmem_gnt_o, imem_gnt_o, mem_addr_o} !== {2'b10, 32'h300}) begin
      failures++; $display("FAIL sim2_data_second got dgnt/ignt=%b addr=%h want 10/00000300", {dmem_gnt_o, imem_gnt_o}, mem_addr_o);
    end
    dmem_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    checks++;
    if ({dmem_rvalid_o, dmem_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
      failures++; $display("FAIL sim2_data_done got rv=%b rdata=%h want 1/cafef00d", dmem_rvalid_o, dmem_rdata_o);
    end
`else
    checks++;
    if ({dmem_gnt_o, imem_gnt_o, mem_addr_o} !== {2'b10, 32'h300}) begin
      failures++; $display("FAIL sim2_data_first got dgnt/ignt=%b addr=%h want 10/00000300", {dmem_gnt_o, imem_gnt_o}, mem_addr_o);
    end
    dmem_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    checks++;
    if ({dmem_rvalid_o, dmem_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
      failures++; $display("FAIL sim2_data_done got rv=%b rdata=%h want 1/cafef00d", dmem_rvalid_o, dmem_rdata_o);
    end
    mem_ready_i = 1'b0;
    tick();
    checks++;
    if ({imem_gnt_o, dmem_gnt_o, mem_addr_o} !== {2'b10, 32'h40}) begin
      failures++; $display("FAIL sim2_fetch_second got ignt/dgnt=%b addr=%h want 10/00000040", {imem_gnt_o, dmem_gnt_o}, mem_addr_o);
    end
    imem_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick();
    checks++;
    if ({imem_rvalid_o, imem_rdata_o} !== {1'b1, 32'h12345678}) begin
      failures++; $display("FAIL sim2_fetch_done got rv=%b rdata=%h want 1/12345678", imem_rvalid_o, imem_rdata_o);
    end
`endif
    mem_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_busy_request;
    imem_req_i = 1'b1; imem_addr_i = 32'h80;
    tick();
    checks++;
    if ({imem_gnt_o, stall_o} !== 2'b10) begin
      failures++; $display("FAIL busy_fetch_grant got ignt/stall=%b want 10", {imem_gnt_o, stall_o});
    end
    imem_req_i = 1'b0;
    dmem_req_i = 1'b1; dmem_wr_i = 1'b0; dmem_byte_i = SZ_WORD; dmem_addr_i = 32'h400;
    #1;
    checks++;
    if ({stall_o, dmem_gnt_o} !== 2'b10) begin
      failures++; $display("FAIL busy_req_rise got stall/dgnt=%b want 10", {stall_o, dmem_gnt_o});
    end
    tick();
    checks++;
    if ({stall_o, dmem_gnt_o, mem_addr_o} !== {2'b10, 32'h80}) begin
      failures++; $display("FAIL busy_ignored got stall/dgnt=%b addr=%h want 10/00000080", {stall_o, dmem_gnt_o}, mem_addr_o);
    end
    mem_ready_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
    tick();
    checks++;
    if ({imem_rvalid_o, dmem_gnt_o, stall_o} !== 3'b101) begin
      failures++; $display("FAIL busy_fetch_done got irv/dgnt/stall=%b want 101", {imem_rvalid_o, dmem_gnt_o, stall_o});
    end
    mem_ready_i = 1'b0;
    tick();
    checks++;
    if ({dmem_gnt_o, stall_o, mem_addr_o} !== {2'b11, 32'h400}) begin
      failures++; $display("FAIL busy_data_grant got dgnt/stall=%b addr=%h want 11/00000400", {dmem_gnt_o, stall_o}, mem_addr_o);
    end
    dmem_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h0F0F0F0F;
    tick();
    checks++;
    if ({dmem_rvalid_o, stall_o, dmem_rdata_o} !== {2'b10, 32'h0F0F0F0F}) begin
      failures++; $display("FAIL busy_data_done got drv/stall=%b rdata=%h want 10/0f0f0f0f", {dmem_rvalid_o, stall_o}, dmem_rdata_o);
    end
    mem_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_txn;
    dmem_req_i = 1'b1; dmem_wr_i = 1'b0; dmem_byte_i = SZ_WORD; dmem_addr_i = 32'h500;
    tick();
    checks++;
    if ({mem_req_o, stall_o} !== 2'b11) begin
      failures++; $display("FAIL rst_mid_busy got req/stall=%b want 11", {mem_req_o, stall_o});
    end
    dmem_req_i = 1'b0; reset_n = 1'b0;
    tick();
    checks++;
    if ({imem_gnt_o, imem_rvalid_o, imem_rdata_o, dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
         mem_req_o, mem_wr_o, mem_byte_o, mem_addr_o, mem_wdata_o, stall_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got req=%b stall=%b addr=%h irdata=%h drdata=%h want all 0",
               mem_req_o, stall_o, mem_addr_o, imem_rdata_o, dmem_rdata_o);
    end
    reset_n = 1'b1; mem_ready_i = 1'b1; mem_rdata_i = 32'h99;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({imem_rvalid_o, dmem_rvalid_o, mem_req_o, dmem_rdata_o} !== '0) begin
        failures++; $display("FAIL rst_late_ready cycle %0d got irv/drv/req=%b drdata=%h want 000/00000000",
                             i, {imem_rvalid_o, dmem_rvalid_o, mem_req_o}, dmem_rdata_o);
      end
    end
    mem_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    imem_req_i = 1'b0; imem_addr_i = '0;
    dmem_req_i = 1'b0; dmem_wr_i = 1'b0; dmem_byte_i = 2'b00;
    dmem_addr_i = '0; dmem_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    test_reset();
    test_single_load();
    test_zero_wait_fetch();
    test_simultaneous();
    test_busy_request();
    test_reset_mid_txn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
